// File: rtl/psum_drain.sv
// -----------------------------------------------------------------------------
// psum_drain
// Output stage below the bottom row of the MAC array. It deskews the per-column
// partial sums into one row vector. Each lane is requantized to signed OUT_W
// bits (round-half-up right shift, optional ReLU, saturation). Results are
// buffered in a FIFO and offered on a valid/ready port. Credit-style in_ready
// tells the array scheduler whether a launched vector is guaranteed a FIFO slot.
//
// Ports
//   i_clk, i_rst_n    clock, synchronous active-low reset
//   i_in_valid        column-0 result of a new vector present this cycle
//   o_in_ready        a vector launched now is guaranteed a FIFO slot
//   i_psum_in         packed skewed partial sums, lane c at [c*PSUM_W +: PSUM_W]
//   i_cfg_shift       right-shift amount (clamped to PSUM_W-1)
//   i_cfg_relu        clamp negative results to zero
//   o_out_valid       FIFO head holds a vector
//   i_out_ready       consumer accepts the head vector
//   o_out_data        packed lanes, lane c at [c*OUT_W +: OUT_W]
//   o_busy            a vector is in flight or buffered
//   o_overflow        sticky: a vector arrived while o_in_ready was low
//   i_clr_ovf         clears o_overflow (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module psum_drain #(
   parameter int COLS   = 8,
   parameter int PSUM_W = 24,
   parameter int OUT_W  = 8,
   parameter int DEPTH  = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   input  logic [COLS*PSUM_W-1:0]  i_psum_in,
   input  logic [4:0]              i_cfg_shift,
   input  logic                    i_cfg_relu,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [COLS*OUT_W-1:0]   o_out_data,
   output logic                    o_busy,
   output logic                    o_overflow,
   input  logic                    i_clr_ovf
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [4:0] MAX_SH = 5'(PSUM_W - 1);
   localparam logic signed [PSUM_W:0] SAT_HI = (PSUM_W+1)'((1 <<< (OUT_W - 1)) - 1);
   localparam logic signed [PSUM_W:0] SAT_LO = (PSUM_W+1)'(-(1 <<< (OUT_W - 1)));

   logic [CW-1:0]          r_inflight;
   logic [CW-1:0]          r_fcnt;
   logic [CW:0]            w_reserved;
   logic                   w_accept;
   logic                   w_drop;
   logic                   w_push;
   logic                   w_pop;
   logic [COLS-2:0]        r_vchain;
   logic                   r_al_vld;
   logic [PSUM_W-1:0]      w_lane_dly [COLS];
   logic [PSUM_W-1:0]      r_al [COLS];
   logic [COLS*OUT_W-1:0]  w_q_vec;
   logic [COLS*OUT_W-1:0]  r_mem [DEPTH];
   logic [AW-1:0]          r_wp;
   logic [AW-1:0]          r_rp;
   logic                   r_ovf;

   function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Round-half-up shift in PSUM_W+1 bits so the rounding bias cannot overflow.
   function automatic logic [OUT_W-1:0] f_requant(input logic [PSUM_W-1:0] p,
                                                  input logic [4:0]        sh,
                                                  input logic              relu);
      logic [4:0]              s;
      logic signed [PSUM_W:0]  w_bias;
      logic signed [PSUM_W:0]  w_sum;
      logic signed [PSUM_W:0]  w_r;
      s      = (sh > MAX_SH) ? MAX_SH : sh;
      w_bias = (s != 5'd0) ? ((PSUM_W+1)'(1) << (s - 5'd1)) : '0;
      w_sum  = $signed({p[PSUM_W-1], p}) + w_bias;
      w_r    = w_sum >>> s;
      if (relu && w_r < 0) w_r = '0;
      if (w_r > SAT_HI) w_r = SAT_HI;
      if (w_r < SAT_LO) w_r = SAT_LO;
      return w_r[OUT_W-1:0];
   endfunction

   // Credits are counted from registered state only.
   assign w_reserved  = {1'b0, r_inflight} + {1'b0, r_fcnt};
   assign o_in_ready  = (w_reserved < (CW+1)'(DEPTH));
   assign w_accept    = i_in_valid & o_in_ready;
   assign w_drop      = i_in_valid & ~o_in_ready;
   assign w_push      = r_al_vld;
   assign o_out_valid = (r_fcnt != '0);
   assign w_pop       = o_out_valid & i_out_ready;
   assign o_out_data  = o_out_valid ? r_mem[r_rp] : '0;
   assign o_busy      = (r_inflight != '0) | (r_fcnt != '0);
   assign o_overflow  = r_ovf;

   // Deskew: lane c runs through COLS-1-c stages; the last lane is used raw.
   for (genvar c = 0; c < COLS; c++) begin : g_lane
      if (c == COLS - 1) begin : g_direct
         assign w_lane_dly[c] = i_psum_in[c*PSUM_W +: PSUM_W];
      end else begin : g_dly
         localparam int N = COLS - 1 - c;
         logic [PSUM_W-1:0] r_dl [N];
         always_ff @(posedge i_clk) begin
            r_dl[0] <= i_psum_in[c*PSUM_W +: PSUM_W];
            for (int unsigned k = 1; k < N; k++) r_dl[k] <= r_dl[k-1];
         end
         assign w_lane_dly[c] = r_dl[N-1];
      end
   end

   always_ff @(posedge i_clk) begin
      for (int unsigned c = 0; c < COLS; c++) r_al[c] <= w_lane_dly[c];
   end

   always_comb begin
      w_q_vec = '0;
      for (int unsigned c = 0; c < COLS; c++)
         w_q_vec[c*OUT_W +: OUT_W] = f_requant(r_al[c], i_cfg_shift, i_cfg_relu);
   end

   // The FIFO entry doubles as the requant register, keeping the
   // in_valid-to-out_valid latency at COLS+1 cycles.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wp] <= w_q_vec;
   end

   // Credits guarantee a push never meets a full FIFO without a same-cycle pop.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_vchain   <= '0;
         r_al_vld   <= 1'b0;
         r_inflight <= '0;
         r_fcnt     <= '0;
         r_wp       <= '0;
         r_rp       <= '0;
         r_ovf      <= 1'b0;
      end else begin
         r_vchain[0] <= w_accept;
         for (int unsigned k = 1; k < COLS - 1; k++) r_vchain[k] <= r_vchain[k-1];
         r_al_vld   <= r_vchain[COLS-2];
         r_inflight <= r_inflight + CW'(w_accept) - CW'(w_push);
         r_fcnt     <= r_fcnt + CW'(w_push) - CW'(w_pop);
         if (w_push) r_wp <= f_inc(r_wp);
         if (w_pop)  r_rp <= f_inc(r_rp);
         if (w_drop)         r_ovf <= 1'b1;
         else if (i_clr_ovf) r_ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_psum_drain.sv
module tb_psum_drain;

   localparam int COLS = 8;
   localparam int PW   = 24;
   localparam int OW   = 8;
   localparam int DEP  = 16;
   localparam int LAT  = COLS + 1;
   localparam int MAXC = 2048;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [COLS*PW-1:0] psum_in = '0;
   logic [4:0]         cfg_shift = '0;
   logic               cfg_relu = 1'b0;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [COLS*OW-1:0] out_data;
   logic               busy;
   logic               overflow;
   logic               clr_ovf = 1'b0;

   always #5 clk = ~clk;

   psum_drain #(.COLS(COLS), .PSUM_W(PW), .OUT_W(OW), .DEPTH(DEP)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_psum_in(psum_in), .i_cfg_shift(cfg_shift), .i_cfg_relu(cfg_relu),
      .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
      .o_busy(busy), .o_overflow(overflow), .i_clr_ovf(clr_ovf)
   );

   typedef struct { int due; logic [63:0] v; } pend_t;

   int                 n_tests = 0;
   int                 n_fail  = 0;
   int                 cyc     = 0;
   bit                 chk_en  = 0;
   logic [COLS*PW-1:0] hist [MAXC];
   bit                 hl   [MAXC];
   logic signed [PW-1:0] nv [COLS];
   pend_t              pend [$];
   logic [63:0]        mq [$];
   bit                 m_ovf = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Requant rule from first principles: floor((p + half) / 2^s), relu, clamp.
   function automatic logic [7:0] ref_q(input longint p, input int sh, input bit relu);
      int s;
      longint d, num, q;
      s   = (sh > 23) ? 23 : sh;
      d   = longint'(1) << s;
      num = p + ((s > 0) ? d / 2 : 0);
      q   = num / d;
      if ((num % d) != 0 && num < 0) q = q - 1;
      if (relu && q < 0) q = 0;
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      return q[7:0];
   endfunction

   function automatic logic [63:0] ref_vec();
      logic [63:0] v;
      v = '0;
      for (int c = 0; c < COLS; c++)
         v[c*8 +: 8] = ref_q(longint'(nv[c]), int'(cfg_shift), cfg_relu);
      return v;
   endfunction

   // One clock cycle: drive inputs, compare outputs with the model, advance model.
   task automatic tick(input bit vld, input bit ordy, input bit clr, input bit rst);
      logic [COLS*PW-1:0] pk;
      logic [COLS*PW-1:0] drv;
      bit                 rdy;
      int                 idx;
      if (cyc >= MAXC - 1) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 1);
         $fatal(1, "cycle budget exhausted");
      end
      pk = '0;
      for (int c = 0; c < COLS; c++) pk[c*PW +: PW] = nv[c];
      hist[cyc] = pk;
      hl[cyc]   = vld;
      for (int c = 0; c < COLS; c++) begin
         idx = cyc - c;
         if (idx >= 0 && hl[idx]) drv[c*PW +: PW] = hist[idx][c*PW +: PW];
         else                     drv[c*PW +: PW] = PW'($urandom);
      end
      psum_in   = drv;
      in_valid  = vld;
      out_ready = ordy;
      clr_ovf   = clr;
      rst_n     = !rst;
      rdy = (pend.size() + mq.size()) < DEP;
      if (chk_en) begin
         check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
         check("out_data",  out_data, (mq.size() != 0) ? mq[0] : 64'd0);
         check("in_ready",  64'(in_ready), 64'(rdy));
         check("busy",      64'(busy), 64'((pend.size() + mq.size()) != 0));
         check("overflow",  64'(overflow), 64'(m_ovf));
      end
      if (rst) begin
         pend.delete();
         mq.delete();
         m_ovf = 0;
      end else begin
         if (vld && rdy) pend.push_back('{due: cyc + LAT, v: ref_vec()});
         if (mq.size() != 0 && ordy) void'(mq.pop_front());
         while (pend.size() != 0 && pend[0].due == cyc + 1) mq.push_back(pend.pop_front().v);
         if (vld && !rdy) m_ovf = 1;
         else if (clr)    m_ovf = 0;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle(input int n, input bit ordy);
      for (int i = 0; i < n; i++) tick(0, ordy, 0, 0);
   endtask

   task automatic set_vec(input int a0, input int a1, input int a2, input int a3,
                          input int a4, input int a5, input int a6, input int a7);
      nv[0] = PW'(a0); nv[1] = PW'(a1); nv[2] = PW'(a2); nv[3] = PW'(a3);
      nv[4] = PW'(a4); nv[5] = PW'(a5); nv[6] = PW'(a6); nv[7] = PW'(a7);
   endtask

   task automatic rand_vec(input int maxsh);
      logic signed [PW-1:0] t;
      for (int c = 0; c < COLS; c++) begin
         t = PW'($urandom);
         nv[c] = t >>> $urandom_range(0, maxsh);
      end
   endtask

   initial begin
      for (int i = 0; i < MAXC; i++) hl[i] = 0;
      for (int c = 0; c < COLS; c++) nv[c] = '0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) tick(0, 0, 0, 1);
      chk_en = 1;
      idle(2, 1);

      // Single vector: lanes 10*c, no shift.
      cfg_shift = 5'd0; cfg_relu = 1'b0;
      set_vec(0, 10, 20, 30, 40, 50, 60, 70);
      tick(1, 1, 0, 0);
      idle(LAT + 3, 1);

      // Rounding and saturation.
      cfg_shift = 5'd4;
      set_vec(24, -24, 5000, -5000, 8, -8, 7, 0);
      tick(1, 1, 0, 0);
      idle(LAT + 3, 1);

      // ReLU.
      cfg_shift = 5'd0; cfg_relu = 1'b1;
      set_vec(-1, -128, 5, 127, -300, 300, 0, -7);
      tick(1, 1, 0, 0);
      idle(LAT + 3, 1);

      // Streaming: 32 back-to-back vectors, shift including values above 23.
      cfg_relu  = 1'b0;
      cfg_shift = 5'($urandom_range(0, 31));
      for (int i = 0; i < 32; i++) begin
         rand_vec(20);
         tick(1, 1, 0, 0);
      end
      idle(LAT + 3, 1);

      // Backpressure: 16 accepted, 17th dropped, drain, then clear overflow.
      cfg_shift = 5'd2;
      for (int i = 0; i < DEP + 1; i++) begin
         rand_vec(16);
         tick(1, 0, 0, 0);
      end
      idle(LAT + 2, 0);
      idle(DEP + 4, 1);
      tick(0, 1, 1, 0);
      idle(2, 1);

      // Random traffic.
      cfg_shift = 5'($urandom_range(0, 24));
      cfg_relu  = 1'($urandom_range(0, 1));
      for (int i = 0; i < 300; i++) begin
         rand_vec(22);
         tick($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
              $urandom_range(0, 19) == 0, 0);
      end
      idle(LAT + DEP + 4, 1);
      tick(0, 1, 1, 0);

      // Reset with 2 vectors buffered and 3 in flight.
      cfg_shift = 5'd1; cfg_relu = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rand_vec(16);
         tick(1, 0, 0, 0);
      end
      idle(LAT - 1, 0);
      for (int i = 0; i < 3; i++) begin
         rand_vec(16);
         tick(1, 0, 0, 0);
      end
      idle(2, 0);
      tick(0, 0, 0, 1);
      idle(LAT + 3, 1);
      set_vec(100, -100, 3, -3, 255, -255, 1, 0);
      tick(1, 1, 0, 0);
      idle(LAT + 3, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
